// File: rtl/ecall_unit.sv
// Environment-call responder: services print/read/exit ecalls from the core,
// holding it stalled until the board I/O (including a debounced confirm button) completes.
module ecall_unit #(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ecall_req,
   input  logic [31:0] a7,
   input  logic [31:0] a0,
   input  logic [15:0] switches,
   input  logic        btn_confirm,
   output logic        ecall_done,
   output logic        ecall_write,
   output logic [31:0] ecall_result,
   output logic [31:0] seg_value,
   output logic        waiting_input,
   output logic        halted
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   localparam logic [31:0] SVC_PRINT     = 32'd1;
   localparam logic [31:0] SVC_READ_INT  = 32'd5;
   localparam logic [31:0] SVC_EXIT      = 32'd10;
   localparam logic [31:0] SVC_READ_CHAR = 32'd12;

   typedef enum logic [2:0] {IDLE, WAIT_REL, WAIT_PRESS, DONE, HALT} state_t;

   state_t         state;
   logic           btn_meta;
   logic           btn_sync;
   logic           btn_db;
   logic [CW-1:0]  db_cnt;
   logic           read_char;

   function automatic logic [31:0] read_value(input logic char_mode, input logic [15:0] sw);
      if (char_mode)
         return {24'd0, sw[7:0]};
      return {{16{sw[15]}}, sw};
   endfunction

   // Debouncer: the synchronized button must disagree with the debounced level
   // for DEBOUNCE_CYCLES consecutive cycles before the debounced level follows it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         btn_meta <= 1'b0;
         btn_sync <= 1'b0;
         btn_db   <= 1'b0;
         db_cnt   <= '0;
      end else begin
         btn_meta <= btn_confirm;
         btn_sync <= btn_meta;
         if (btn_sync == btn_db) begin
            db_cnt <= '0;
         end else if (db_cnt == CNT_LAST) begin
            btn_db <= btn_sync;
            db_cnt <= '0;
         end else begin
            db_cnt <= db_cnt + CW'(1);
         end
      end
   end

   // Service FSM; every output is a flop loaded alongside the state it belongs to,
   // so done/write never see a combinational path from the request inputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         seg_value     <= '0;
         ecall_result  <= '0;
         ecall_done    <= 1'b0;
         ecall_write   <= 1'b0;
         waiting_input <= 1'b0;
         halted        <= 1'b0;
         read_char     <= 1'b0;
      end else begin
         ecall_done  <= 1'b0;
         ecall_write <= 1'b0;
         case (state)
            IDLE: begin
               if (ecall_req) begin
                  case (a7)
                     SVC_PRINT: begin
                        seg_value  <= a0;
                        ecall_done <= 1'b1;
                        state      <= DONE;
                     end
                     SVC_READ_INT, SVC_READ_CHAR: begin
                        read_char     <= (a7 == SVC_READ_CHAR);
                        ecall_result  <= read_value(a7 == SVC_READ_CHAR, switches);
                        waiting_input <= 1'b1;
                        state         <= btn_db ? WAIT_REL : WAIT_PRESS;
                     end
                     SVC_EXIT: begin
                        halted <= 1'b1;
                        state  <= HALT;
                     end
                     default: begin
                        ecall_done <= 1'b1;
                        state      <= DONE;
                     end
                  endcase
               end
            end
            // A press already held when the read began must be released first.
            WAIT_REL: begin
               if (!btn_db)
                  state <= WAIT_PRESS;
            end
            WAIT_PRESS: begin
               if (btn_db) begin
                  ecall_result  <= read_value(read_char, switches);
                  ecall_done    <= 1'b1;
                  ecall_write   <= 1'b1;
                  waiting_input <= 1'b0;
                  state         <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            HALT: begin
               state <= HALT;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ecall_unit.sv
// Randomized self-checking bench for ecall_unit against a cycle-level behavioural model.
module tb_ecall_unit;

   localparam int DB = 4;
   localparam int P_IDLE = 0, P_REL = 1, P_PRESS = 2, P_DONE = 3, P_HALT = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ecall_req = 1'b0;
   logic [31:0] a7 = '0;
   logic [31:0] a0 = '0;
   logic [15:0] switches = '0;
   logic        btn_confirm = 1'b0;
   logic        ecall_done;
   logic        ecall_write;
   logic [31:0] ecall_result;
   logic [31:0] seg_value;
   logic        waiting_input;
   logic        halted;

   int n_checks = 0;
   int n_fail = 0;

   int          dut_done_cnt = 0;
   int          dut_write_cnt = 0;
   logic [31:0] dut_last_result = '0;

   int          m_phase = P_IDLE;
   bit          m_rd = 0;
   bit          m_char = 0;
   bit          m_db = 0;
   logic [31:0] m_seg = '0;
   logic [31:0] m_result = '0;
   logic [31:0] m_last_result = '0;
   int          m_done_cnt = 0;
   int          m_write_cnt = 0;
   bit          hist[$];

   ecall_unit #(.DEBOUNCE_CYCLES(DB)) dut (
      .clk(clk), .rst(rst), .ecall_req(ecall_req), .a7(a7), .a0(a0),
      .switches(switches), .btn_confirm(btn_confirm), .ecall_done(ecall_done),
      .ecall_write(ecall_write), .ecall_result(ecall_result), .seg_value(seg_value),
      .waiting_input(waiting_input), .halted(halted)
   );

   always #5 clk = ~clk;

   // Observe every pulse the DUT emits, whenever it happens.
   always @(negedge clk) begin
      if (ecall_done) dut_done_cnt <= dut_done_cnt + 1;
      if (ecall_write) begin
         dut_write_cnt   <= dut_write_cnt + 1;
         dut_last_result <= ecall_result;
      end
   end

   function automatic logic [31:0] expect_read(bit ch, logic [15:0] sw);
      if (ch) return 32'(sw % 256);
      if (sw >= 16'h8000) return 32'(sw) - 32'd65536;
      return 32'(sw);
   endfunction

   task automatic model_reset();
      m_phase = P_IDLE; m_rd = 0; m_char = 0; m_db = 0;
      m_seg = '0; m_result = '0;
      hist = '{0, 0, 0, 0, 0, 0};
   endtask

   // One clock cycle: predict the edge from the inputs held now, then advance the DUT.
   task automatic step();
      bit db_before;
      bit all_differ;
      db_before = m_db;
      case (m_phase)
         P_IDLE: if (ecall_req) begin
            if (a7 == 1) begin m_seg = a0; m_rd = 0; m_phase = P_DONE; end
            else if (a7 == 5 || a7 == 12) begin
               m_char = (a7 == 12); m_rd = 1;
               m_result = expect_read(m_char, switches);
               m_phase = db_before ? P_REL : P_PRESS;
            end
            else if (a7 == 10) m_phase = P_HALT;
            else begin m_rd = 0; m_phase = P_DONE; end
         end
         P_REL: if (!db_before) m_phase = P_PRESS;
         P_PRESS: if (db_before) begin m_result = expect_read(m_char, switches); m_phase = P_DONE; end
         P_DONE: m_phase = P_IDLE;
         default: m_phase = m_phase;
      endcase
      hist.push_front(btn_confirm);
      void'(hist.pop_back());
      all_differ = (hist[2] != m_db) && (hist[3] != m_db) && (hist[4] != m_db) && (hist[5] != m_db);
      if (all_differ) m_db = !m_db;
      @(posedge clk);
      @(negedge clk);
      #1;
      if (m_phase == P_DONE) begin
         m_done_cnt++;
         if (m_rd) begin m_write_cnt++; m_last_result = m_result; end
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      model_reset();
      #1;
      n_checks++; if (ecall_done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done: got %0b want 0", ecall_done); end
      n_checks++; if (ecall_write !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_write: got %0b want 0", ecall_write); end
      n_checks++; if (ecall_result !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_result: got %h want 0", ecall_result); end
      n_checks++; if (seg_value !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_seg: got %h want 0", seg_value); end
      n_checks++; if (waiting_input !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_wait: got %0b want 0", waiting_input); end
      n_checks++; if (halted !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_halted: got %0b want 0", halted); end
      @(negedge clk);
      rst = 1'b1;
      #1;
   endtask

   task automatic test_print();
      for (int i = 0; i < 4; i++) begin
         a7 = 32'd1; a0 = (i == 0) ? 32'h0000_00FF : $urandom; ecall_req = 1'b1;
         step();
         ecall_req = 1'b0; a0 = $urandom;
         n_checks++; if (seg_value !== m_seg) begin n_fail++; $display("[TB] FAIL print_seg: got %h want %h", seg_value, m_seg); end
         n_checks++; if (ecall_done !== 1'b1) begin n_fail++; $display("[TB] FAIL print_done: got %0b want 1", ecall_done); end
         n_checks++; if (ecall_write !== 1'b0) begin n_fail++; $display("[TB] FAIL print_write: got %0b want 0", ecall_write); end
         step();
         n_checks++; if (ecall_done !== 1'b0) begin n_fail++; $display("[TB] FAIL print_done_width: got %0b want 0", ecall_done); end
      end
   endtask

   task automatic test_unknown();
      logic [31:0] seg_before;
      for (int i = 0; i < 3; i++) begin
         seg_before = m_seg;
         a7 = (i == 0) ? 32'd99 : 32'd13 + 32'($urandom_range(0, 5000)); a0 = $urandom; ecall_req = 1'b1;
         step();
         ecall_req = 1'b0;
         n_checks++; if (ecall_done !== 1'b1) begin n_fail++; $display("[TB] FAIL unknown_done: got %0b want 1", ecall_done); end
         n_checks++; if (ecall_write !== 1'b0) begin n_fail++; $display("[TB] FAIL unknown_write: got %0b want 0", ecall_write); end
         n_checks++; if (seg_value !== seg_before) begin n_fail++; $display("[TB] FAIL unknown_seg: got %h want %h", seg_value, seg_before); end
         step();
      end
   endtask

   task automatic test_read_int();
      int d0;
      int w0;
      d0 = dut_done_cnt; w0 = dut_write_cnt;
      switches = 16'h8001; a7 = 32'd5; btn_confirm = 1'b0; ecall_req = 1'b1;
      step();
      ecall_req = 1'b0;
      n_checks++; if (waiting_input !== 1'b1) begin n_fail++; $display("[TB] FAIL read_int_wait: got %0b want 1", waiting_input); end
      btn_confirm = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         n_checks++; if (waiting_input !== (m_phase == P_REL || m_phase == P_PRESS)) begin n_fail++; $display("[TB] FAIL read_int_wait_cycle%0d: got %0b", i, waiting_input); end
      end
      btn_confirm = 1'b0;
      repeat (8) step();
      n_checks++; if (dut_done_cnt - d0 !== 1) begin n_fail++; $display("[TB] FAIL read_int_done_count: got %0d want 1", dut_done_cnt - d0); end
      n_checks++; if (dut_write_cnt - w0 !== 1) begin n_fail++; $display("[TB] FAIL read_int_write_count: got %0d want 1", dut_write_cnt - w0); end
      n_checks++; if (dut_last_result !== 32'hFFFF_8001) begin n_fail++; $display("[TB] FAIL read_int_result: got %h want ffff8001", dut_last_result); end
   endtask

   task automatic test_read_char_held();
      int d0;
      d0 = dut_done_cnt;
      btn_confirm = 1'b1;
      repeat (8) step();
      switches = 16'h12AB; a7 = 32'd12; ecall_req = 1'b1;
      step();
      ecall_req = 1'b0;
      repeat (10) step();
      n_checks++; if (waiting_input !== 1'b1) begin n_fail++; $display("[TB] FAIL char_held_wait: got %0b want 1", waiting_input); end
      n_checks++; if (dut_done_cnt !== d0) begin n_fail++; $display("[TB] FAIL char_held_early_done: got %0d want %0d", dut_done_cnt, d0); end
      btn_confirm = 1'b0;
      repeat (8) step();
      btn_confirm = 1'b1;
      repeat (8) step();
      btn_confirm = 1'b0;
      repeat (8) step();
      n_checks++; if (dut_done_cnt - d0 !== 1) begin n_fail++; $display("[TB] FAIL char_held_done_count: got %0d want 1", dut_done_cnt - d0); end
      n_checks++; if (dut_last_result !== 32'h0000_00AB) begin n_fail++; $display("[TB] FAIL char_held_result: got %h want 000000ab", dut_last_result); end
   endtask

   task automatic test_bounce();
      int d0;
      d0 = dut_done_cnt;
      switches = 16'($urandom); a7 = 32'd5; btn_confirm = 1'b0; ecall_req = 1'b1;
      step();
      ecall_req = 1'b0;
      for (int i = 0; i < 20; i++) begin
         btn_confirm = ((i / 2) % 2 == 0);
         step();
      end
      n_checks++; if (dut_done_cnt !== d0) begin n_fail++; $display("[TB] FAIL bounce_spurious_done: got %0d want %0d", dut_done_cnt, d0); end
      btn_confirm = 1'b1;
      switches = 16'($urandom);
      repeat (6) step();
      n_checks++; if (ecall_done !== 1'b0 || m_phase == P_DONE) begin n_fail++; $display("[TB] FAIL bounce_done_too_early: got %0b want 0", ecall_done); end
      step();
      n_checks++; if (ecall_done !== 1'b1 || m_phase != P_DONE) begin n_fail++; $display("[TB] FAIL bounce_done_at_7: got %0b want 1", ecall_done); end
      n_checks++; if (ecall_result !== m_result) begin n_fail++; $display("[TB] FAIL bounce_result: got %h want %h", ecall_result, m_result); end
      btn_confirm = 1'b0;
      repeat (8) step();
   endtask

   task automatic test_back_to_back();
      int d0;
      int md0;
      d0 = dut_done_cnt; md0 = m_done_cnt;
      a7 = 32'd1; ecall_req = 1'b1;
      for (int i = 0; i < 10; i++) begin
         a0 = $urandom;
         step();
      end
      ecall_req = 1'b0;
      step();
      n_checks++; if (dut_done_cnt - d0 !== m_done_cnt - md0) begin n_fail++; $display("[TB] FAIL b2b_done_count: got %0d want %0d", dut_done_cnt - d0, m_done_cnt - md0); end
      n_checks++; if (seg_value !== m_seg) begin n_fail++; $display("[TB] FAIL b2b_seg: got %h want %h", seg_value, m_seg); end
   endtask

   task automatic test_random_reads();
      int d0, w0, md0, mw0, seg_len;
      for (int it = 0; it < 6; it++) begin
         d0 = dut_done_cnt; w0 = dut_write_cnt; md0 = m_done_cnt; mw0 = m_write_cnt;
         btn_confirm = $urandom_range(0, 1);
         repeat (8) step();
         a7 = ($urandom_range(0, 1) == 1) ? 32'd12 : 32'd5;
         switches = 16'($urandom); ecall_req = 1'b1;
         step();
         ecall_req = 1'b0;
         for (int c = 0; c < 40; c += seg_len) begin
            seg_len = $urandom_range(1, 8);
            btn_confirm = $urandom_range(0, 1);
            if ($urandom_range(0, 3) == 0) switches = 16'($urandom);
            repeat (seg_len) step();
         end
         btn_confirm = 1'b0; repeat (8) step();
         btn_confirm = 1'b1; repeat (8) step();
         btn_confirm = 1'b0; repeat (8) step();
         n_checks++; if (dut_done_cnt - d0 !== m_done_cnt - md0) begin n_fail++; $display("[TB] FAIL rand_read%0d_done: got %0d want %0d", it, dut_done_cnt - d0, m_done_cnt - md0); end
         n_checks++; if (dut_write_cnt - w0 !== m_write_cnt - mw0) begin n_fail++; $display("[TB] FAIL rand_read%0d_write: got %0d want %0d", it, dut_write_cnt - w0, m_write_cnt - mw0); end
         n_checks++; if (dut_last_result !== m_last_result) begin n_fail++; $display("[TB] FAIL rand_read%0d_result: got %h want %h", it, dut_last_result, m_last_result); end
      end
   endtask

   task automatic test_reset_midservice();
      int d0;
      int w0;
      a7 = 32'd5; switches = 16'($urandom); btn_confirm = 1'b0; ecall_req = 1'b1;
      step();
      ecall_req = 1'b0;
      repeat (3) step();
      d0 = dut_done_cnt; w0 = dut_write_cnt;
      #2;
      rst = 1'b0;
      model_reset();
      #1;
      n_checks++; if (waiting_input !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_wait: got %0b want 0", waiting_input); end
      btn_confirm = 1'b1;
      repeat (2) @(negedge clk);
      btn_confirm = 1'b0;
      rst = 1'b1;
      #1;
      repeat (10) step();
      n_checks++; if (dut_done_cnt !== d0 || dut_write_cnt !== w0) begin n_fail++; $display("[TB] FAIL midreset_pulses: got done %0d write %0d want %0d %0d", dut_done_cnt, dut_write_cnt, d0, w0); end
      n_checks++; if (waiting_input !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_idle: got %0b want 0", waiting_input); end
   endtask

   task automatic test_exit();
      int d0;
      a7 = 32'd10; ecall_req = 1'b1;
      step();
      n_checks++; if (halted !== 1'b1) begin n_fail++; $display("[TB] FAIL exit_halted: got %0b want 1", halted); end
      d0 = dut_done_cnt;
      for (int i = 0; i < 100; i++) begin
         ecall_req = $urandom_range(0, 1);
         a7 = ($urandom_range(0, 1) == 1) ? 32'd1 : 32'd99;
         btn_confirm = $urandom_range(0, 1);
         step();
      end
      ecall_req = 1'b0; btn_confirm = 1'b0;
      n_checks++; if (dut_done_cnt !== d0) begin n_fail++; $display("[TB] FAIL exit_done_while_halted: got %0d want %0d", dut_done_cnt, d0); end
      n_checks++; if (halted !== 1'b1) begin n_fail++; $display("[TB] FAIL exit_halted_held: got %0b want 1", halted); end
      #2;
      rst = 1'b0;
      model_reset();
      #1;
      n_checks++; if (halted !== 1'b0) begin n_fail++; $display("[TB] FAIL exit_async_reset: got %0b want 0", halted); end
      @(negedge clk);
      rst = 1'b1;
      #1;
      a7 = 32'd1; a0 = 32'h1234_5678; ecall_req = 1'b1;
      step();
      ecall_req = 1'b0;
      n_checks++; if (ecall_done !== 1'b1) begin n_fail++; $display("[TB] FAIL exit_after_reset_done: got %0b want 1", ecall_done); end
      step();
   endtask

   initial begin
      test_reset();
      test_print();
      test_unknown();
      test_read_int();
      test_read_char_held();
      test_bounce();
      test_back_to_back();
      test_random_reads();
      test_reset_midservice();
      test_exit();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
